serial_adder: RTL

//   Bit-serial N-bit adder built around one full-adder bit cell plus a carry

---
 rtl/serial_adder_if.sv | 31 +++
 rtl/serial_adder.sv | 91 +++++++++
 2 files changed

// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. The ovf signal exists only when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, WIDTH clocks.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, sum_r;
  logic             c_r, carry_r;
  logic [CW-1:0]    cnt;
  logic             s_bit, c_nx, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_r;
`endif

  // The single full-adder cell
  assign s_bit = a_sh[0] ^ b_sh[0] ^ c_r;
  assign c_nx  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c_r) | (b_sh[0] & c_r);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      c_r     <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sh   <= bus.a;
          b_sh   <= bus.b;
          c_r    <= bus.cin;
          cnt    <= '0;
          res_sh <= '0;
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c_r    <= c_nx;
          res_sh <= {s_bit, res_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          // Final step: publish result including the bit computed this edge
          if (last) begin
            sum_r   <= {s_bit, res_sh[WIDTH-1:1]};
            carry_r <= c_nx;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= c_r ^ c_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_r;
  assign bus.carry = carry_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf   = ovf_r;
`endif
endmodule
